// File: rtl/dna_axi_lite_pkg.sv
// Shared types and constants for the DNA AXI-Lite initiator.
`timescale 1ns/1ps
package dna_axi_lite_pkg;

    // Transaction sequencing states; one transaction in flight at a time.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything other than OKAY, EXOKAY included, is reported to the requester as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/dna_axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: local command in, AXI-Lite transaction out,
// completion (status + read data) back to the requester.
`timescale 1ns/1ps
module dna_axi_lite_master
    import dna_axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    // command side
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_we,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
    // completion side
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    // AXI write address
    output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
    output logic                    o_axi_awvalid,
    input  logic                    i_axi_awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0]   o_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] o_axi_wstrb,
    output logic                    o_axi_wvalid,
    input  logic                    i_axi_wready,
    // AXI write response
    input  logic [1:0]              i_axi_bresp,
    input  logic                    i_axi_bvalid,
    output logic                    o_axi_bready,
    // AXI read address
    output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
    output logic                    o_axi_arvalid,
    input  logic                    i_axi_arready,
    // AXI read data
    input  logic [DATA_WIDTH-1:0]   i_axi_rdata,
    input  logic [1:0]              i_axi_rresp,
    input  logic                    i_axi_rvalid,
    output logic                    o_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    // Next-state and next-output decode; every output flop is loaded with the value it
    // must show in the state being entered, so all AXI/response outputs come straight off flops.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wdata;
                    wstrb_d = i_cmd_wstrb;
                    if (i_cmd_we) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end

            ST_WR_REQ: begin
                // AW and W retire independently, in either order or together.
                if (awvalid_q && i_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && i_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end

            ST_WR_RESP: begin
                if (i_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rdata_d     = '0;
                    err_d       = resp_is_err(i_axi_bresp);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end

            ST_RD_REQ: begin
                if (i_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_RESP;
                end
            end

            ST_RD_RESP: begin
                if (i_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rdata_d     = i_axi_rdata;
                    err_d       = resp_is_err(i_axi_rresp);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                // rdata/err stay put until the requester takes the completion.
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight AXI transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Command ready is decoded from state, masked while reset is held so it rises
    // only once reset has been released.
    always_comb begin
        o_cmd_ready = (state_q == ST_IDLE) && !reset;
    end

    assign o_axi_awaddr  = addr_q;
    assign o_axi_araddr  = addr_q;
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_bready  = bready_q;
    assign o_axi_rready  = rready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_err     = err_q;

endmodule

// File: tb/tb_dna_axi_lite_master.sv
// Directed, table-driven bench for dna_axi_lite_master with a cycle-scripted AXI-Lite slave.
`timescale 1ns/1ps
module tb_dna_axi_lite_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_we;
    logic [31:0] i_cmd_addr, i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic [31:0] o_axi_awaddr, o_axi_wdata, o_axi_araddr, i_axi_rdata;
    logic [3:0]  o_axi_wstrb;
    logic        o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready;
    logic [1:0]  i_axi_bresp, i_axi_rresp;
    logic        i_axi_bvalid, o_axi_bready, o_axi_arvalid, i_axi_arready;
    logic        i_axi_rvalid, o_axi_rready;

    always #5 clk = ~clk;

    dna_axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
        .i_axi_wready(i_axi_wready),
        .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp), .i_axi_rvalid(i_axi_rvalid),
        .o_axi_rready(o_axi_rready)
    );

    // One command plus the slave's behaviour and the hand-computed completion.
    // exp_cyc: cycle (command accepted = 0) in which o_rsp_valid is first seen.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          resp_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
        int          hold;
    } vec_t;

    vec_t vecs[8];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic slave_idle();
        i_axi_awready = 0; i_axi_wready = 0; i_axi_arready = 0;
        i_axi_bvalid = 0; i_axi_bresp = 0;
        i_axi_rvalid = 0; i_axi_rresp = 0; i_axi_rdata = 0;
    endtask

    // Issue one command from IDLE (called on a falling edge), play the slave, check the
    // completion, hold it for v.hold cycles, then retire it.
    task automatic run_vec(input vec_t v, input int idx);
        int          cyc, aw_hs, w_hs, ar_hs, b_hs, r_hs, resp_at;
        bit          prot_ok, got_rsp, aw_seen, w_seen, ar_seen, stable;
        logic [31:0] rd0;
        logic        err0;
        logic [39:0] hs_exp;
        cyc = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; resp_at = -1;
        prot_ok = 1; got_rsp = 0; aw_seen = 0; w_seen = 0; ar_seen = 0;

        chk($sformatf("v%0d_cmd_ready", idx), 64'(o_cmd_ready), 64'(1));
        i_cmd_valid = 1; i_cmd_we = v.we; i_cmd_addr = v.addr;
        i_cmd_wdata = v.wdata; i_cmd_wstrb = v.wstrb;

        while (!got_rsp && cyc < 40) begin
            @(negedge clk);
            cyc++;
            i_cmd_valid = 0;
            slave_idle();
            if (o_rsp_valid) begin
                got_rsp = 1;
            end else begin
                if (o_cmd_ready) prot_ok = 0;
                if ((o_axi_bready || o_axi_rready) && resp_at < 0) prot_ok = 0;
                i_axi_awready = (cyc >= 1 + v.aw_dly);
                i_axi_wready  = (cyc >= 1 + v.w_dly);
                i_axi_arready = (cyc >= 1 + v.ar_dly);
                if (o_axi_awvalid) begin
                    aw_seen = 1;
                    if (o_axi_awaddr !== v.addr) prot_ok = 0;
                    if (i_axi_awready) aw_hs++;
                end else if (aw_seen && aw_hs == 0) prot_ok = 0;
                if (o_axi_wvalid) begin
                    w_seen = 1;
                    if (o_axi_wdata !== v.wdata || o_axi_wstrb !== v.wstrb) prot_ok = 0;
                    if (i_axi_wready) w_hs++;
                end else if (w_seen && w_hs == 0) prot_ok = 0;
                if (o_axi_arvalid) begin
                    ar_seen = 1;
                    if (o_axi_araddr !== v.addr) prot_ok = 0;
                    if (i_axi_arready) ar_hs++;
                end else if (ar_seen && ar_hs == 0) prot_ok = 0;
                if (resp_at < 0) begin
                    if (v.we && aw_hs > 0 && w_hs > 0) resp_at = cyc + 1 + v.resp_dly;
                    if (!v.we && ar_hs > 0)            resp_at = cyc + 1 + v.resp_dly;
                end else if (cyc >= resp_at && b_hs == 0 && r_hs == 0) begin
                    if (v.we) begin
                        i_axi_bvalid = 1; i_axi_bresp = v.resp;
                        if (o_axi_bready) b_hs++;
                    end else begin
                        i_axi_rvalid = 1; i_axi_rresp = v.resp; i_axi_rdata = v.rdata;
                        if (o_axi_rready) r_hs++;
                    end
                end
            end
        end

        chk($sformatf("v%0d_rsp_cycle", idx), 64'(cyc), 64'(v.exp_cyc));
        if (!got_rsp) begin
            reset = 1; @(negedge clk); reset = 0; @(negedge clk);
            return;
        end
        chk($sformatf("v%0d_rdata", idx), 64'(o_rsp_rdata), 64'(v.exp_rdata));
        chk($sformatf("v%0d_err", idx), 64'(o_rsp_err), 64'(v.exp_err));
        hs_exp = v.we ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01;
        chk($sformatf("v%0d_handshakes", idx),
            64'({aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0], r_hs[7:0]}), 64'(hs_exp));
        chk($sformatf("v%0d_protocol", idx), 64'(prot_ok), 64'(1));

        rd0 = o_rsp_rdata; err0 = o_rsp_err; stable = 1;
        i_rsp_ready = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!o_rsp_valid || o_rsp_rdata !== rd0 || o_rsp_err !== err0) stable = 0;
        end
        if (v.hold > 0) chk($sformatf("v%0d_rsp_stable", idx), 64'(stable), 64'(1));
        i_rsp_ready = 1;
        @(negedge clk);
        i_rsp_ready = 0;
        chk($sformatf("v%0d_retire", idx), 64'({o_rsp_valid, o_cmd_ready}), 64'(2'b01));
    endtask

    initial begin
        //           we  addr          wdata         strb  aw w  ar rsp resp         rdata         exp_rdata     err  cyc hold
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1'b0, 3, 0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 0, 3, 2'b00, 32'h1234_5678, 32'h1234_5678, 1'b0, 6, 0};
        vecs[2] = '{1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 4'h3, 2, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1'b0, 5, 1};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 0, 0, 2'b10, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 3, 5};
        vecs[4] = '{1'b1, 32'h0000_0044, 32'h1111_2222, 4'h8, 0, 0, 0, 0, 2'b11, 32'h0, 32'h0, 1'b1, 3, 5};
        vecs[5] = '{1'b1, 32'h0000_0048, 32'h5555_AAAA, 4'hC, 0, 3, 0, 0, 2'b01, 32'h0, 32'h0, 1'b1, 6, 0};
        vecs[6] = '{1'b0, 32'h0000_004C, 32'h0,         4'h0, 0, 0, 2, 1, 2'b00, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 6, 2};
        vecs[7] = '{1'b0, 32'h0000_0060, 32'h0,         4'h0, 0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3, 0};

        reset = 1; i_cmd_valid = 0; i_cmd_we = 0; i_cmd_addr = 0; i_cmd_wdata = 0;
        i_cmd_wstrb = 0; i_rsp_ready = 0;
        slave_idle();
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            64'({o_cmd_ready, o_rsp_valid, o_rsp_err, o_axi_awvalid, o_axi_wvalid,
                 o_axi_arvalid, o_axi_bready, o_axi_rready}), 64'(0));
        chk("reset_regs", 64'({o_axi_awaddr, o_rsp_rdata}), 64'(0));
        reset = 0;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(o_cmd_ready), 64'(1));

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset in WR_REQ with the slave holding awready/wready low.
        i_cmd_valid = 1; i_cmd_we = 1; i_cmd_addr = 32'h0000_0050;
        i_cmd_wdata = 32'h7777_8888; i_cmd_wstrb = 4'hF;
        @(negedge clk);
        i_cmd_valid = 0;
        chk("rst_mid_valids_up", 64'({o_axi_awvalid, o_axi_wvalid}), 64'(2'b11));
        #2 reset = 1;
        #1;
        chk("rst_mid_valids_down",
            64'({o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_bready,
                 o_axi_rready, o_rsp_valid, o_cmd_ready}), 64'(0));
        chk("rst_mid_regs", 64'({o_axi_awaddr, o_axi_wdata}), 64'(0));
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_mid_recover", 64'({o_cmd_ready, o_axi_awvalid, o_axi_wvalid}), 64'(3'b100));
        run_vec(vecs[7], 7);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // Hard backstop in case a stimulus loop misbehaves.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d", n_pass, n_tot);
        $fatal(1);
    end

endmodule

// File: doc/dna_axi_lite_master.md
# dna_axi_lite_master

AXI-Lite initiator that turns single-beat write/read commands from a local requester (core-side bus bridge or DMA engine) into AXI-Lite transactions, and returns completion status plus read data. It sits on the requester side of the DNA memory-mapped fabric and drives AXI-Lite slave ports in that fabric. One transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of command and AXI address channels
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  block accepts command (high only in IDLE)
- i_cmd_we  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_WIDTH  target address
- i_cmd_wdata  in  DATA_WIDTH  write data
- i_cmd_wstrb  in  DATA_WIDTH/8  byte strobes
- o_rsp_valid  out  1  completion available
- i_rsp_ready  in  1  requester takes completion
- o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- o_rsp_err  out  1  BRESP/RRESP was not OKAY
- o_axi_awaddr/o_axi_awvalid out, i_axi_awready in  write address channel
- o_axi_wdata/o_axi_wstrb/o_axi_wvalid out, i_axi_wready in  write data channel
- i_axi_bresp (2) / i_axi_bvalid in, o_axi_bready out  write response
- o_axi_araddr/o_axi_arvalid out, i_axi_arready in  read address channel
- i_axi_rdata / i_axi_rresp (2) / i_axi_rvalid in, o_axi_rready out  read data

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: o_cmd_ready=1. On i_cmd_valid: latch addr/wdata/wstrb into AXI output registers; go WR_REQ (we=1) or RD_REQ (we=0).
- WR_REQ: awvalid and wvalid both asserted on entry; each drops independently the cycle after its own handshake (valid&ready). Channels may complete in either order or the same cycle. When both complete -> WR_RESP.
- WR_RESP: o_axi_bready=1; on bvalid: capture err=(bresp!=OKAY), rdata=0 -> RSP.
- RD_REQ: arvalid=1 until arready; then -> RD_RESP.
- RD_RESP: o_axi_rready=1; on rvalid: capture rdata and err=(rresp!=OKAY) -> RSP.
- RSP: o_rsp_valid=1, rdata/err held stable until i_rsp_ready; then -> IDLE.
- AXI valids never drop before handshake; addr/data/strb stable while valid is high.
- Reset (any state, mid-transaction included): state IDLE; all valid/ready outputs 0, o_cmd_ready goes 1 after reset deasserts; address/data/rdata/err registers 0. Abandoned AXI transaction is not completed.

## Timing
- All outputs registered except o_cmd_ready (decoded from state register).
- Write, zero-wait slave: command accepted cycle 0; aw/w handshake cycle 1; bvalid earliest cycle 2; o_rsp_valid cycle 3.
- Read, zero-wait slave: accept 0; ar handshake 1; rvalid earliest 2; o_rsp_valid 3.
- Back-to-back: new command accepted the cycle o_rsp_valid&i_rsp_ready completes + 1 (IDLE cycle); throughput one transaction per 4 cycles minimum.
- Slave stalls extend the corresponding state indefinitely; no timeout.
- bready/rready asserted only in their response states; a response arriving earlier is not accepted until then.

## Structure
- Shared package dna_axi_lite_pkg: state localparams, RESP codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
- Single flat module; no sub-module is natural at this size.

## Test plan
- Write 0x0000_0010 data 0xDEAD_BEEF strb 0xF, zero-wait slave, bresp OKAY -> awvalid/wvalid cycle 1, o_rsp_valid cycle 3, err=0, rdata=0.
- Read 0x0000_0020, slave returns 0x1234_5678 after 3 rvalid-stall cycles, rresp OKAY -> o_rsp_rdata=0x1234_5678, err=0, rsp_valid 3 cycles later than zero-wait case.
- Write with awready delayed 2 cycles, wready immediate -> wvalid drops after cycle 1, awvalid held stable to cycle 3, single bready handshake, one response.
- Read with rresp=SLVERR, then write with bresp=DECERR -> err=1 on both; i_rsp_ready held low 5 cycles -> rsp_valid/rdata/err stable throughout.
- Reset asserted in WR_REQ with awvalid high -> all AXI valids 0 immediately, o_rsp_valid 0; after release next read command completes normally.
